// File: rtl/sobel_pkg.sv
// Shared constants, slice-index helpers and the saturating output functions
// of the 3x3 frame correlation engine.
package sobel_pkg;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int PIX_W  = 5;
  localparam int COEF_W = 3;
  localparam int OUT_W  = 8;
  // Worst-case magnitude is 9*31*4 = 1116, so 13 signed bits suffice.
  localparam int ACC_W  = 13;

  localparam int OUT_C  = IMG_W - 2;
  localparam int OUT_R  = IMG_H - 2;
  localparam int OUT_N  = OUT_R * OUT_C;
  localparam int A_W    = IMG_W * IMG_H * PIX_W;
  localparam int B_W    = 9 * COEF_W;
  localparam int RES_W  = OUT_N * OUT_W;

  typedef logic        [PIX_W-1:0]  pix_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic        [OUT_W-1:0]  res_t;

  // Element 0 sits at the MSB end of each flat bus.
  function automatic int pix_lsb(input int k);
    return A_W - PIX_W * (k + 1);
  endfunction

  function automatic int coef_lsb(input int n);
    return B_W - COEF_W * (n + 1);
  endfunction

  function automatic int res_lsb(input int m);
    return RES_W - OUT_W * (m + 1);
  endfunction

  function automatic res_t sat_abs(input acc_t s);
    acc_t mag;
    mag = (s < acc_t'(0)) ? -s : s;
    return (mag > acc_t'(255)) ? res_t'(255) : res_t'(mag);
  endfunction

  function automatic res_t sat_s8(input acc_t s);
    if (s > acc_t'(127))       return res_t'(8'h7F);
    else if (s < acc_t'(-128)) return res_t'(8'h80);
    else                       return res_t'(s);
  endfunction
endpackage

// File: rtl/sobel_window_mac.sv
// Combinational 3x3 multiply-accumulate: zero-extended pixels times signed
// coefficients, summed into a signed ACC_W result.
module sobel_window_mac
  import sobel_pkg::*;
(
  input  pix_t  [8:0] pix,
  input  coef_t [8:0] coef,
  output acc_t        sum
);

  always_comb begin
    sum = '0;
    for (int n = 0; n < 9; n++)
      sum = sum + acc_t'($signed(coef[n])) * acc_t'($signed({1'b0, pix[n]}));
  end

endmodule

// File: rtl/sobel_filter_core.sv
// Whole-frame 3x3 correlation, two register stages (sums, then saturated
// results). Compile-time option SOBEL_ABS_EN selects |S| clamped to 255.
module sobel_filter_core
  import sobel_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [A_W-1:0]   A,
  input  logic [B_W-1:0]   B,
  output logic             out_valid,
  output logic [RES_W-1:0] Res
);

  localparam int STAGES = 2;

  coef_t [8:0]     coef;
  acc_t            sum_w [OUT_N];
  acc_t            s_q   [OUT_N];
  logic [STAGES:1] vld_pipe;

  function automatic res_t post_fn(input acc_t s);
`ifdef SOBEL_ABS_EN
    return sat_abs(s);
`else
    return sat_s8(s);
`endif
  endfunction

  for (genvar n = 0; n < 9; n++) begin : g_coef
    assign coef[n] = B[coef_lsb(n) +: COEF_W];
  end

  for (genvar i = 0; i < OUT_R; i++) begin : g_row
    for (genvar j = 0; j < OUT_C; j++) begin : g_col
      pix_t [8:0] pix;
      for (genvar u = 0; u < 3; u++) begin : g_u
        for (genvar v = 0; v < 3; v++) begin : g_v
          assign pix[u*3+v] = A[pix_lsb((i+u)*IMG_W + j + v) +: PIX_W];
        end
      end
      sobel_window_mac u_mac (
        .pix  (pix),
        .coef (coef),
        .sum  (sum_w[i*OUT_C+j])
      );
    end
  end

  // Sums and results only load on their stage's valid; otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      Res      <= '0;
      for (int m = 0; m < OUT_N; m++) s_q[m] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid)
        for (int m = 0; m < OUT_N; m++) s_q[m] <= sum_w[m];
      if (vld_pipe[1])
        for (int m = 0; m < OUT_N; m++) Res[res_lsb(m) +: OUT_W] <= post_fn(s_q[m]);
    end
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_sobel_filter_core.sv
// Directed bench for sobel_filter_core: constant, Sobel-Y, identity,
// streaming and mid-pipeline reset frames with hand-derived expectations.
module tb_sobel_filter_core;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [3919:0] A;
  logic [26:0]   B;
  logic          out_valid;
  logic [5407:0] Res;

  int ncmp = 0;
  int nerr = 0;

`ifdef SOBEL_ABS_EN
  localparam logic [7:0] E_POS = 8'hFF;
  localparam logic [7:0] E_NEG = 8'hFF;
  localparam logic [7:0] E_SY  = 8'h08;
`else
  localparam logic [7:0] E_POS = 8'h7F;
  localparam logic [7:0] E_NEG = 8'h80;
  localparam logic [7:0] E_SY  = 8'hF8;
`endif

  sobel_filter_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .Res       (Res)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: constant v, 1: pixel = row index, 2: pixel k = k%32
  function automatic logic [3919:0] frm(input int mode, input logic [4:0] v);
    logic [3919:0] r;
    r = '0;
    for (int k = 0; k < 784; k++) begin
      case (mode)
        0:       r[3915-5*k +: 5] = v;
        1:       r[3915-5*k +: 5] = 5'(k / 28);
        default: r[3915-5*k +: 5] = 5'(k % 32);
      endcase
    end
    return r;
  endfunction

  function automatic logic [5407:0] exp_ident();
    logic [5407:0] r;
    r = '0;
    for (int i = 0; i < 26; i++)
      for (int j = 0; j < 26; j++)
        r[5400-8*(i*26+j) +: 8] = 8'(((i+1)*28 + j + 1) % 32);
    return r;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [5407:0] exp);
    int bad;
    bad = 0;
    for (int m = 675; m >= 0; m--)
      if (Res[5400-8*m +: 8] !== exp[5400-8*m +: 8]) bad = m;
    ncmp++;
    assert (Res === exp) else begin
      nerr++;
      $error("FAIL %s: res[%0d] got %h want %h", tag, bad,
             Res[5400-8*bad +: 8], exp[5400-8*bad +: 8]);
    end
  endtask

  // One isolated frame: latency, strobe width, content, and hold afterwards.
  task automatic run_frame(input string tag, input logic [3919:0] a,
                           input logic [26:0] b, input logic [5407:0] exp);
    A = a; B = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_bit({tag, "_lat1"}, out_valid, 1'b0);
    tick();
    chk_bit({tag, "_valid"}, out_valid, 1'b1);
    chk_frame({tag, "_res"}, exp);
    tick();
    chk_bit({tag, "_strobe"}, out_valid, 1'b0);
    chk_frame({tag, "_hold"}, exp);
  endtask

  logic [26:0] k_sy;
  logic [26:0] k_id;

  initial begin
    k_sy = {3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'b111, 3'b110, 3'b111};
    k_id = {12'b0, 3'b001, 12'b0};
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0;
    tick(); tick();
    chk_bit("rst_valid", out_valid, 1'b0);
    chk_frame("rst_res", '0);
    rst_n = 1'b1;
    tick();

    run_frame("zero",  '0,                27'h5A5A5A5,    '0);
    run_frame("satp",  frm(0, 5'd31),     {9{3'b001}},    {676{E_POS}});
    run_frame("satn",  frm(0, 5'd31),     {9{3'b100}},    {676{E_NEG}});
    run_frame("sobly", frm(1, 5'd0),      k_sy,           {676{E_SY}});
    run_frame("ident", frm(2, 5'd0),      k_id,           exp_ident());

    // Back-to-back frames: identity, Sobel-Y, positive saturation.
    A = frm(2, 5'd0); B = k_id; in_valid = 1'b1;
    tick();
    chk_bit("strm_lat", out_valid, 1'b0);
    A = frm(1, 5'd0); B = k_sy;
    tick();
    chk_bit("strm_v0", out_valid, 1'b1);
    chk_frame("strm_f0", exp_ident());
    A = frm(0, 5'd31); B = {9{3'b001}};
    tick();
    in_valid = 1'b0;
    chk_bit("strm_v1", out_valid, 1'b1);
    chk_frame("strm_f1", {676{E_SY}});
    tick();
    chk_bit("strm_v2", out_valid, 1'b1);
    chk_frame("strm_f2", {676{E_POS}});
    tick();
    chk_bit("strm_end", out_valid, 1'b0);
    chk_frame("strm_hold", {676{E_POS}});

    // Reset with two frames in flight.
    A = frm(0, 5'd31); B = {9{3'b100}}; in_valid = 1'b1;
    tick();
    A = frm(1, 5'd0); B = k_sy;
    tick();
    chk_bit("rstm_pre", out_valid, 1'b1);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk_bit("rstm_valid", out_valid, 1'b0);
    chk_frame("rstm_res", '0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk_bit("rstm_idle", out_valid, 1'b0);
    chk_frame("rstm_idle_res", '0);
    run_frame("post_rst", frm(2, 5'd0), k_id, exp_ident());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
